// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared types for the RaveNoC edge terminator.
//   flit_type_t : flit framing type, carried in the top two flit bits.
//   edge_mode_t : behaviour of a boundary port terminator.
//   vc_state_t  : per-VC framing tracker state.
//   vc_width()  : VC id width, at least one bit even for a single VC.
package ravenoc_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    EDGE_TIEOFF    = 2'd0,
    EDGE_DRAIN     = 2'd1,
    EDGE_DRAIN_IRQ = 2'd2
  } edge_mode_t;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_IN_PKT = 1'b1
  } vc_state_t;

  function automatic int vc_width(input int n_vc);
    return (n_vc > 1) ? $clog2(n_vc) : 1;
  endfunction

endpackage

// File: rtl/ravenoc_edge_vc_fsm.sv
// ravenoc_edge_vc_fsm: packet framing tracker for one virtual channel.
//   clk_noc, arst_noc : clock, async active-low reset
//   accept            : a flit on this VC is consumed this cycle
//   flit_type         : type of that flit
//   in_pkt            : registered "inside packet" state
//   pkt_evt, err_evt  : same-cycle strobes for a completed packet / framing error
//
// state     | meaning
// VC_IDLE   | between packets, expecting HEAD or HEAD_TAIL
// VC_IN_PKT | a HEAD was seen, expecting BODY or TAIL
module ravenoc_edge_vc_fsm
  import ravenoc_pkg::*;
(
  input  logic       clk_noc,
  input  logic       arst_noc,
  input  logic       accept,
  input  flit_type_t flit_type,
  output logic       in_pkt,
  output logic       pkt_evt,
  output logic       err_evt
);

  vc_state_t state;

  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      state <= VC_IDLE;
    end else if (accept) begin
      case (state)
        VC_IDLE:   if (flit_type == HEAD) state <= VC_IN_PKT;
        VC_IN_PKT: if (flit_type == TAIL || flit_type == HEAD_TAIL) state <= VC_IDLE;
      endcase
    end
  end

  assign in_pkt = (state == VC_IN_PKT);

  // A HEAD while inside a packet restarts the packet; HEAD_TAIL there both
  // flags the truncation and counts itself as a complete packet.
  always_comb begin
    pkt_evt = 1'b0;
    err_evt = 1'b0;
    if (accept) begin
      case (state)
        VC_IDLE: begin
          pkt_evt = (flit_type == HEAD_TAIL);
          err_evt = (flit_type == BODY) || (flit_type == TAIL);
        end
        VC_IN_PKT: begin
          pkt_evt = (flit_type == TAIL) || (flit_type == HEAD_TAIL);
          err_evt = (flit_type == HEAD) || (flit_type == HEAD_TAIL);
        end
      endcase
    end
  end

endmodule

// File: rtl/ravenoc_edge_sink.sv
// ravenoc_edge_sink: terminator for an unused boundary router port.
//   clk_noc, arst_noc      : clock, async active-low reset
//   flit_valid/vc/data     : flits leaving the router through this port
//   flit_ready [N_VC]      : registered per-VC ready (all 0 in EDGE_TIEOFF)
//   send_valid, send_data  : toward the router, tied to 0
//   clr_stats              : clears counters and irq; a same-cycle event wins
//   pkt_cnt [N_VC*CNT_W]   : saturating dropped-packet count, VC v at [v*CNT_W +: CNT_W]
//   err_cnt [CNT_W]        : saturating framing-error count over all VCs
//   in_pkt [N_VC]          : per-VC inside-packet state
//   irq                    : sticky interrupt
module ravenoc_edge_sink
  import ravenoc_pkg::*;
#(
  parameter int         FLIT_WIDTH = 34,
  parameter int         N_VC       = 2,
  parameter int         CNT_W      = 16,
  parameter edge_mode_t MODE       = EDGE_TIEOFF,
  localparam int        VC_W       = vc_width(N_VC)
) (
  input  logic                    clk_noc,
  input  logic                    arst_noc,
  input  logic                    flit_valid,
  input  logic [VC_W-1:0]         flit_vc,
  input  logic [FLIT_WIDTH-1:0]   flit_data,
  output logic [N_VC-1:0]         flit_ready,
  output logic                    send_valid,
  output logic [FLIT_WIDTH-1:0]   send_data,
  input  logic                    clr_stats,
  output logic [N_VC*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [N_VC-1:0]         in_pkt,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               DRAIN      = (MODE != EDGE_TIEOFF);
  localparam bit               IRQ_ON_PKT = (MODE == EDGE_DRAIN_IRQ);

  logic [N_VC-1:0] ready_q;
  logic [N_VC-1:0] accept;
  logic [N_VC-1:0] pkt_evt;
  logic [N_VC-1:0] err_evt;
  flit_type_t      flit_type;
  logic            unused_payload;

  assign flit_type      = flit_type_t'(flit_data[FLIT_WIDTH-1 -: 2]);
  assign unused_payload = ^flit_data[FLIT_WIDTH-3:0];

  // Registered so ready never depends combinationally on anything; it
  // rises on the first edge after reset release in the drain modes.
  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) ready_q <= '0;
    else           ready_q <= DRAIN ? '1 : '0;
  end

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;

    // An out-of-range flit_vc matches no VC, so it is never accepted.
    assign accept[v] = flit_valid && ready_q[v] && (flit_vc == VC_W'(v));

    ravenoc_edge_vc_fsm u_fsm (
      .clk_noc   (clk_noc),
      .arst_noc  (arst_noc),
      .accept    (accept[v]),
      .flit_type (flit_type),
      .in_pkt    (in_pkt[v]),
      .pkt_evt   (pkt_evt[v]),
      .err_evt   (err_evt[v])
    );

    // Clear first, then increment, so a coinciding event leaves a count of 1.
    assign cnt_base = clr_stats ? '0 : cnt_q;

    always_ff @(posedge clk_noc or negedge arst_noc) begin
      if (!arst_noc)                               cnt_q <= '0;
      else if (pkt_evt[v] && cnt_base != CNT_MAX) cnt_q <= cnt_base + CNT_W'(1);
      else                                         cnt_q <= cnt_base;
    end

    assign pkt_cnt[v*CNT_W +: CNT_W] = cnt_q;
  end

  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W:0]   err_sum;

  assign err_base = clr_stats ? '0 : err_q;

  // One extra bit catches overflow for saturation.
  always_comb begin
    err_sum = {1'b0, err_base};
    for (int v = 0; v < N_VC; v++) begin
      err_sum = err_sum + {{CNT_W{1'b0}}, err_evt[v]};
    end
  end

  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) err_q <= '0;
    else           err_q <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
  end

  logic irq_q;
  logic irq_set;

  assign irq_set = (|err_evt) || (IRQ_ON_PKT && (|pkt_evt));

  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) irq_q <= 1'b0;
    else           irq_q <= (irq_q && !clr_stats) || irq_set;
  end

  assign flit_ready = ready_q;
  assign err_cnt    = err_q;
  assign irq        = irq_q;
  assign send_valid = 1'b0;
  assign send_data  = '0;

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
module tb_ravenoc_edge_sink;
  import ravenoc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flit_valid;
  logic        flit_vc;
  logic [1:0]  vc3;
  logic [33:0] flit_data;
  logic        clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut_d: EDGE_DRAIN, dut_i: EDGE_DRAIN_IRQ, dut_s: EDGE_DRAIN_IRQ with 4-bit counters,
  // dut_t: EDGE_TIEOFF, dut_o: EDGE_DRAIN with 3 VCs (out-of-range VC id 3).
  logic [1:0]  rdy_d, rdy_i, rdy_s, rdy_t;
  logic [2:0]  rdy_o;
  logic        sv_d, sv_i, sv_s, sv_t, sv_o;
  logic [33:0] sd_d, sd_i, sd_s, sd_t, sd_o;
  logic [31:0] pkt_d, pkt_i, pkt_t;
  logic [7:0]  pkt_s;
  logic [47:0] pkt_o;
  logic [15:0] err_d, err_i, err_t, err_o;
  logic [3:0]  err_s;
  logic [1:0]  inp_d, inp_i, inp_s, inp_t;
  logic [2:0]  inp_o;
  logic        irq_d, irq_i, irq_s, irq_t, irq_o;

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VC(2), .CNT_W(16), .MODE(EDGE_DRAIN)) dut_d (
    .clk_noc(clk), .arst_noc(rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_data(flit_data), .flit_ready(rdy_d), .send_valid(sv_d), .send_data(sd_d),
    .clr_stats(clr), .pkt_cnt(pkt_d), .err_cnt(err_d), .in_pkt(inp_d), .irq(irq_d));

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VC(2), .CNT_W(16), .MODE(EDGE_DRAIN_IRQ)) dut_i (
    .clk_noc(clk), .arst_noc(rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_data(flit_data), .flit_ready(rdy_i), .send_valid(sv_i), .send_data(sd_i),
    .clr_stats(clr), .pkt_cnt(pkt_i), .err_cnt(err_i), .in_pkt(inp_i), .irq(irq_i));

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VC(2), .CNT_W(4), .MODE(EDGE_DRAIN_IRQ)) dut_s (
    .clk_noc(clk), .arst_noc(rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_data(flit_data), .flit_ready(rdy_s), .send_valid(sv_s), .send_data(sd_s),
    .clr_stats(clr), .pkt_cnt(pkt_s), .err_cnt(err_s), .in_pkt(inp_s), .irq(irq_s));

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VC(2), .CNT_W(16), .MODE(EDGE_TIEOFF)) dut_t (
    .clk_noc(clk), .arst_noc(rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_data(flit_data), .flit_ready(rdy_t), .send_valid(sv_t), .send_data(sd_t),
    .clr_stats(clr), .pkt_cnt(pkt_t), .err_cnt(err_t), .in_pkt(inp_t), .irq(irq_t));

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VC(3), .CNT_W(16), .MODE(EDGE_DRAIN)) dut_o (
    .clk_noc(clk), .arst_noc(rst_n), .flit_valid(flit_valid), .flit_vc(vc3),
    .flit_data(flit_data), .flit_ready(rdy_o), .send_valid(sv_o), .send_data(sd_o),
    .clr_stats(clr), .pkt_cnt(pkt_o), .err_cnt(err_o), .in_pkt(inp_o), .irq(irq_o));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [1:0] t);
    flit_valid = 1'b1;
    flit_vc    = c;
    vc3        = {1'b0, c};
    flit_data  = {t, 32'hA5C3_0F00 ^ 32'($urandom_range(0, 255))};
  endtask

  task automatic idle();
    flit_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; flit_valid = 1'b0; flit_vc = 1'b0; vc3 = 2'd0; flit_data = '0; clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_d", rdy_d, 2'b00);
    chk("rst_ready_o", rdy_o, 3'b000);
    chk("rst_pkt_d", pkt_d, 0);
    chk("rst_err_d", err_d, 0);
    chk("rst_inpkt_d", inp_d, 0);
    chk("rst_irq_i", irq_i, 0);
    chk("rst_send_valid", sv_d, 0);
    chk("rst_send_data", sd_d, 0);

    rst_n = 1'b1;
    #3;
    chk("ready_before_edge", rdy_d, 2'b00);
    step();
    chk("ready_after_edge_d", rdy_d, 2'b11);
    chk("ready_after_edge_o", rdy_o, 3'b111);
    chk("ready_tieoff", rdy_t, 2'b00);
    chk("idle_irq_d", irq_d, 0);

    // VC1 packet HEAD BODY BODY TAIL
    drive(1'b1, HEAD);      step(); chk("vc1_head_inpkt", inp_d, 2'b10);
    drive(1'b1, BODY);      step(); chk("vc1_body1_inpkt", inp_d, 2'b10);
    drive(1'b1, BODY);      step(); chk("vc1_body2_inpkt", inp_d, 2'b10);
    chk("vc1_mid_pkt", pkt_d, 0);
    drive(1'b1, TAIL);      step(); idle();
    chk("vc1_tail_inpkt", inp_d, 2'b00);
    chk("vc1_pkt_d", pkt_d, {16'd1, 16'd0});
    chk("vc1_pkt_s", pkt_s, {4'd1, 4'd0});
    chk("vc1_err_d", err_d, 0);
    chk("vc1_irq_drain", irq_d, 0);
    chk("vc1_irq_drain_irq", irq_i, 1);
    chk("vc1_pkt_tieoff", pkt_t, 0);
    chk("vc1_inpkt_tieoff", inp_t, 0);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_pkt_d", pkt_d, 0);
    chk("clr_irq_i", irq_i, 0);

    // Framing errors on VC0
    drive(1'b0, TAIL);      step(); chk("err_tail_idle", err_d, 1);
    drive(1'b0, HEAD);      step(); chk("err_head_inpkt", inp_d, 2'b01);
    drive(1'b0, HEAD);      step(); chk("err_head_head", err_d, 2);
    chk("err_head_head_inpkt", inp_d, 2'b01);
    drive(1'b0, HEAD_TAIL); step(); idle();
    chk("err_total_d", err_d, 3);
    chk("err_total_s", err_s, 3);
    chk("err_pkt_d", pkt_d, {16'd0, 16'd1});
    chk("err_inpkt_d", inp_d, 2'b00);
    chk("err_irq_drain", irq_d, 1);
    chk("err_irq_drain_irq", irq_i, 1);
    chk("err_irq_tieoff", irq_t, 0);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr2_err_d", err_d, 0);
    chk("clr2_irq_d", irq_d, 0);

    // Out-of-range VC id on the 3-VC instance
    drive(1'b0, TAIL); vc3 = 2'd3; step(); idle();
    chk("oor_err_o", err_o, 0);
    chk("oor_pkt_o", pkt_o, 0);
    chk("oor_irq_o", irq_o, 0);
    chk("oor_err_d", err_d, 1);
    drive(1'b0, HEAD_TAIL); vc3 = 2'd2; step(); idle();
    chk("vc2_pkt_o", pkt_o, {16'd1, 32'd0});
    chk("vc2_err_o", err_o, 0);

    clr = 1'b1; step(); clr = 1'b0;

    // Saturation with 4-bit counters
    repeat (15) begin drive(1'b0, HEAD_TAIL); step(); end
    idle();
    chk("sat15_pkt_s", pkt_s, {4'd0, 4'd15});
    repeat (2) begin drive(1'b0, HEAD_TAIL); step(); end
    idle();
    chk("sat17_pkt_s", pkt_s, {4'd0, 4'd15});
    chk("sat17_pkt_d", pkt_d, {16'd0, 16'd17});
    chk("sat17_err_s", err_s, 0);
    chk("sat17_irq_s", irq_s, 1);
    chk("sat17_irq_d", irq_d, 0);

    // clr_stats coinciding with an accepted TAIL
    drive(1'b0, HEAD); step();
    drive(1'b0, TAIL); clr = 1'b1; step(); clr = 1'b0; idle();
    chk("clrevt_pkt_d", pkt_d, {16'd0, 16'd1});
    chk("clrevt_pkt_s", pkt_s, {4'd0, 4'd1});
    chk("clrevt_err_i", err_i, 0);
    chk("clrevt_irq_i", irq_i, 1);
    chk("clrevt_irq_s", irq_s, 1);
    chk("clrevt_irq_d", irq_d, 0);

    // 100 cycles of valid traffic, alternating VCs
    for (int i = 0; i < 100; i++) begin
      drive(i[0], HEAD_TAIL);
      step();
      chk("tieoff_ready", rdy_t, 2'b00);
    end
    idle();
    chk("tieoff_pkt", pkt_t, 0);
    chk("tieoff_err", err_t, 0);
    chk("tieoff_irq", irq_t, 0);
    chk("tieoff_inpkt", inp_t, 0);
    chk("tieoff_send_valid", sv_t, 0);
    chk("burst_pkt_d", pkt_d, {16'd50, 16'd51});
    chk("burst_pkt_s", pkt_s, {4'd15, 4'd15});

    // Reset mid-packet
    drive(1'b1, HEAD); step(); idle();
    chk("midrst_inpkt_before", inp_d, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_inpkt_async", inp_d, 2'b00);
    chk("midrst_ready_async", rdy_d, 2'b00);
    chk("midrst_pkt_async", pkt_d, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_ready_back", rdy_d, 2'b11);
    drive(1'b1, BODY); step(); idle();
    chk("midrst_body_err", err_d, 1);
    chk("midrst_body_inpkt", inp_d, 2'b00);
    chk("final_send_data_i", sd_i, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ravenoc_edge_sink.md
# ravenoc_edge_sink

Parametrised edge terminator for the RaveNoC mesh, the successor to the fixed tie-off placed on unconnected router ports at the mesh boundary. It sits on one unused north/south/west/east port of a boundary router. It either back-pressures that port permanently, or drains and discards stray flits while tracking packet framing per virtual channel. It counts dropped packets and framing errors and raises a sticky IRQ, so a routing bug that targets a non-existent neighbour becomes visible instead of deadlocking.

## Interface
- FLIT_WIDTH, 34: flit width in bits; the top 2 bits carry the flit type.
- N_VC, 2: number of virtual channels; N_VC ≥ 1.
- CNT_W, 16: width of each statistics counter.
- MODE, EDGE_TIEOFF: one of EDGE_TIEOFF, EDGE_DRAIN, EDGE_DRAIN_IRQ.
- clk_noc  in  1  NoC clock; single clock domain.
- arst_noc  in  1  asynchronous, active-low reset.
- flit_valid  in  1  incoming flit valid, from the router's outward send side.
- flit_vc  in  $clog2(N_VC) (min 1)  VC id of the incoming flit.
- flit_data  in  FLIT_WIDTH  flit payload; [FLIT_WIDTH-1:FLIT_WIDTH-2] is the type.
- flit_ready  out  N_VC  per-VC ready back to the router.
- send_valid  out  1  toward the router's receive side; constant 0.
- send_data  out  FLIT_WIDTH  constant 0.
- clr_stats  in  1  single-cycle pulse that clears the counters and the IRQ.
- pkt_cnt  out  N_VC*CNT_W  dropped-packet count per VC; VC v occupies [v*CNT_W +: CNT_W].
- err_cnt  out  CNT_W  framing-error count, summed over all VCs.
- in_pkt  out  N_VC  per-VC "inside packet" state.
- irq  out  1  sticky error/drop interrupt.

## Operation
- Accept condition: flit_valid & flit_ready[flit_vc].
- EDGE_TIEOFF:
  - flit_ready = 0 always, so nothing is ever accepted.
  - Counters, in_pkt and irq stay at 0.
- EDGE_DRAIN and EDGE_DRAIN_IRQ:
  - flit_ready = all ones.
  - Every accepted flit is discarded.
- One 2-state FSM per VC, IDLE / IN_PKT; in_pkt[v] = (state == IN_PKT).
- Flit types: HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11.
- Transitions for an accepted flit on VC v:
  - IDLE, HEAD → IN_PKT.
  - IDLE, HEAD_TAIL → pkt++, stay IDLE.
  - IDLE, BODY or TAIL → err++, stay IDLE.
  - IN_PKT, BODY → stay.
  - IN_PKT, TAIL → pkt++, go to IDLE.
  - IN_PKT, HEAD → err++, stay IN_PKT (a new packet restarts).
  - IN_PKT, HEAD_TAIL → err++ and pkt++, go to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- irq:
  - EDGE_DRAIN_IRQ: set by any pkt++ or err++.
  - EDGE_DRAIN: set by err++ only.
  - Cleared only by clr_stats.
- clr_stats:
  - Zeroes all counters and irq.
  - Does not alter the FSM state.
  - If an event coincides with clr_stats, the result is counter = 1 and irq = 1 (the increment applies on top of the clear; set beats clear).
- Out-of-range flit_vc (≥ N_VC when N_VC is not a power of 2): ready for it is 0 and the flit is never accepted.

## Timing
- Reset values: flit_ready = 0, every counter = 0, in_pkt = 0, irq = 0, send_valid = 0, send_data = 0.
- flit_ready is registered. In the drain modes it rises on the first clk_noc edge after arst_noc deasserts.
- Accepted flits are consumed in the cycle of acceptance; throughput is one flit per cycle with zero stall.
- pkt_cnt, err_cnt, in_pkt and irq update on the clock edge that ends the accept cycle, i.e. they are visible one cycle later.
- When reset asserts mid-packet, the FSM returns to IDLE immediately (asynchronously). No error is counted for the truncated packet.
- Every output is driven directly from a flop or a constant; there is no combinational path from input to output.

## Structure
- Shared ravenoc_pkg additions:
  - typedef enum logic [1:0] flit_type_t (HEAD, BODY, TAIL, HEAD_TAIL).
  - typedef enum edge_mode_t (EDGE_TIEOFF, EDGE_DRAIN, EDGE_DRAIN_IRQ).
- Sub-module ravenoc_edge_vc_fsm, one instance per VC, generated N_VC times:
  - Inputs: accept strobe and flit type.
  - Outputs: in_pkt, pkt_evt, err_evt.
- Top level holds the saturating counters, the error adder across VCs, and the irq flop.
- The mesh top instantiates this block in place of the current boundary tie-off, with MODE selectable per edge.

## Test plan
- Reset release with MODE = EDGE_DRAIN, N_VC = 2 → flit_ready = 2'b00 during reset, 2'b11 exactly one edge after deassertion; every other output stays 0.
- VC1 sends HEAD, BODY, BODY, TAIL back-to-back → in_pkt[1] = 1 for cycles 2–4. After the TAIL, pkt_cnt[VC1] = 1 and irq = 0 (EDGE_DRAIN). In EDGE_DRAIN_IRQ, irq = 1.
- Framing errors: TAIL on idle VC0, then HEAD, HEAD, HEAD_TAIL on VC0 → err_cnt = 3, pkt_cnt[VC0] = 1, in_pkt[0] = 0, irq = 1.
- CNT_W = 4, 17 HEAD_TAIL flits on VC0 → pkt_cnt[VC0] holds at 15.
- clr_stats in the same cycle as an accepted TAIL on VC0 → pkt_cnt[VC0] = 1, irq = 1, err_cnt = 0.
- MODE = EDGE_TIEOFF with flit_valid held high for 100 cycles → flit_ready = 0 throughout; all counters 0 and irq 0.
